// File: rtl/l3_kernel_scheduler.sv
// C3 kernel-pair sequencer: streams 151-word filters from the dual-port weight ROM, then runs conv per pair.
// Optional busy-cycle counter output perf_cycles enabled by defining L3_SCHED_PERF_EN.
module l3_kernel_scheduler #(
    parameter int DATA_WIDTH    = 12,
    parameter int KERNEL_PAIRS  = 8,
    parameter int FILTER_WORDS  = 151,
    parameter int FILTER_BASE_0 = 0,
    parameter int FILTER_BASE_1 = 1208,
    parameter int READ_LATENCY  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  conv_done,
    output logic [DATA_WIDTH-1:0] weight_addra,
    output logic [DATA_WIDTH-1:0] weight_addrb,
    output logic                  weight_valid,
    output logic [7:0]            weight_index,
    output logic [2:0]            kernel_idx,
    output logic                  conv_start,
    output logic                  busy,
    output logic                  done
`ifdef L3_SCHED_PERF_EN
    ,
    output logic [15:0]           perf_cycles
`endif
);

    localparam int DCW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

    typedef enum logic [4:0] {
        S_IDLE  = 5'b00001,
        S_LOAD  = 5'b00010,
        S_DRAIN = 5'b00100,
        S_CONV  = 5'b01000,
        S_FIN   = 5'b10000
    } state_t;

    state_t                r_st;
    state_t                w_st_nxt;
    logic [7:0]            r_wc;
    logic [7:0]            w_wc_nxt;
    logic [2:0]            r_kidx;
    logic [2:0]            w_kidx_nxt;
    logic [DCW-1:0]        r_dcnt;
    logic [DCW-1:0]        w_dcnt_nxt;
    logic                  r_conv_first;
    logic                  w_conv_first_nxt;
    logic                  w_conv_start;
    logic                  w_busy;
    logic                  w_done;
    logic [DATA_WIDTH-1:0] r_addra;
    logic [DATA_WIDTH-1:0] r_addrb;
    logic [DATA_WIDTH-1:0] w_addra_nxt;
    logic [DATA_WIDTH-1:0] w_addrb_nxt;
    logic [DATA_WIDTH-1:0] w_pair_off;
    logic                  r_vpipe [READ_LATENCY];
    logic [7:0]            r_ipipe [READ_LATENCY];

    always_comb begin
        w_st_nxt         = r_st;
        w_wc_nxt         = r_wc;
        w_kidx_nxt       = r_kidx;
        w_dcnt_nxt       = r_dcnt;
        w_conv_first_nxt = 1'b0;
        w_conv_start     = 1'b0;
        w_busy           = 1'b0;
        w_done           = 1'b0;
        case (r_st)
            S_IDLE: begin
                if (start) begin
                    w_st_nxt   = S_LOAD;
                    w_wc_nxt   = '0;
                    w_kidx_nxt = '0;
                end
            end
            S_LOAD: begin
                w_busy   = 1'b1;
                w_wc_nxt = r_wc + 8'd1;
                if (r_wc == 8'(FILTER_WORDS - 1)) begin
                    w_st_nxt   = S_DRAIN;
                    w_dcnt_nxt = '0;
                end
            end
            S_DRAIN: begin
                w_busy = 1'b1;
                if (r_dcnt == DCW'(READ_LATENCY - 1)) begin
                    w_st_nxt         = S_CONV;
                    w_conv_first_nxt = 1'b1;
                end else begin
                    w_dcnt_nxt = r_dcnt + 1'b1;
                end
            end
            S_CONV: begin
                w_busy       = 1'b1;
                w_conv_start = r_conv_first;
                // conv_done is only honoured once the start pulse has been issued
                if (!r_conv_first && conv_done) begin
                    if (r_kidx == 3'(KERNEL_PAIRS - 1)) begin
                        w_st_nxt = S_FIN;
                    end else begin
                        w_st_nxt   = S_LOAD;
                        w_kidx_nxt = r_kidx + 3'd1;
                        w_wc_nxt   = '0;
                    end
                end
            end
            S_FIN: begin
                w_done   = 1'b1;
                w_st_nxt = S_IDLE;
            end
            default: w_st_nxt = S_IDLE;
        endcase
    end

    // Addresses are computed from next-cycle counters so the register shows word wc during the LOAD cycle itself
    assign w_pair_off  = DATA_WIDTH'(w_kidx_nxt) * DATA_WIDTH'(FILTER_WORDS) + DATA_WIDTH'(w_wc_nxt);
    assign w_addra_nxt = DATA_WIDTH'(FILTER_BASE_0) + w_pair_off;
    assign w_addrb_nxt = DATA_WIDTH'(FILTER_BASE_1) + w_pair_off;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_st         <= S_IDLE;
            r_wc         <= '0;
            r_kidx       <= '0;
            r_dcnt       <= '0;
            r_conv_first <= 1'b0;
            r_addra      <= '0;
            r_addrb      <= '0;
        end else begin
            r_st         <= w_st_nxt;
            r_wc         <= w_wc_nxt;
            r_kidx       <= w_kidx_nxt;
            r_dcnt       <= w_dcnt_nxt;
            r_conv_first <= w_conv_first_nxt;
            if (w_st_nxt == S_LOAD) begin
                r_addra <= w_addra_nxt;
                r_addrb <= w_addrb_nxt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned i = 0; i < READ_LATENCY; i++) begin
                r_vpipe[i] <= 1'b0;
                r_ipipe[i] <= '0;
            end
        end else begin
            r_vpipe[0] <= (r_st == S_LOAD);
            r_ipipe[0] <= r_wc;
            for (int unsigned i = 1; i < READ_LATENCY; i++) begin
                r_vpipe[i] <= r_vpipe[i-1];
                r_ipipe[i] <= r_ipipe[i-1];
            end
        end
    end

`ifdef L3_SCHED_PERF_EN
    logic [15:0] r_perf;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_perf <= '0;
        end else if (r_st == S_IDLE && start) begin
            r_perf <= '0;
        end else if (w_busy && r_perf != '1) begin
            r_perf <= r_perf + 16'd1;
        end
    end

    assign perf_cycles = r_perf;
`endif

    assign weight_addra = r_addra;
    assign weight_addrb = r_addrb;
    assign weight_valid = r_vpipe[READ_LATENCY-1];
    assign weight_index = r_ipipe[READ_LATENCY-1];
    assign kernel_idx   = r_kidx;
    assign conv_start   = w_conv_start;
    assign busy         = w_busy;
    assign done         = w_done;

endmodule

// File: tb/tb_l3_kernel_scheduler.sv
// Randomized bench for l3_kernel_scheduler against a timeline model built from per-pair period arithmetic.
module tb_l3_kernel_scheduler;

    localparam int DW  = 12;
    localparam int KP  = 8;
    localparam int FW  = 151;
    localparam int B0  = 0;
    localparam int B1  = 1208;
    localparam int LAT = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          conv_done = 1'b0;
    logic [DW-1:0] weight_addra;
    logic [DW-1:0] weight_addrb;
    logic          weight_valid;
    logic [7:0]    weight_index;
    logic [2:0]    kernel_idx;
    logic          conv_start;
    logic          busy;
    logic          done;
`ifdef L3_SCHED_PERF_EN
    logic [15:0]   perf_cycles;
`endif

    l3_kernel_scheduler #(
        .DATA_WIDTH   (DW),
        .KERNEL_PAIRS (KP),
        .FILTER_WORDS (FW),
        .FILTER_BASE_0(B0),
        .FILTER_BASE_1(B1),
        .READ_LATENCY (LAT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .conv_done    (conv_done),
        .weight_addra (weight_addra),
        .weight_addrb (weight_addrb),
        .weight_valid (weight_valid),
        .weight_index (weight_index),
        .kernel_idx   (kernel_idx),
        .conv_start   (conv_start),
        .busy         (busy),
        .done         (done)
`ifdef L3_SCHED_PERF_EN
        ,
        .perf_cycles  (perf_cycles)
`endif
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    // Reference model: a run is a start cycle plus per-pair periods FW + LAT + D + 1
    bit m_run = 0;
    int m_t0 = 0;
    int m_d [KP];
    int m_len [KP];
    int m_total = 0;
    int m_hold_a = 0;
    int m_hold_b = 0;
    int m_hold_k = 0;
    int m_perf = 0;

    bit pol_cd_hold = 0;
    bit pol_stray = 0;
    bit pol_start_noise = 0;
    bit pol_start_hold = 0;
    bit req_start = 0;
    int pol_rst_o = -1;

    int cnt_v = 0;
    int cnt_cs = 0;
    int cnt_done = 0;
    int last_done_cyc = 0;
    int hist_a [16];
    int hist_b [16];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
    endtask

    task automatic set_delays(input int dmin, input int dmax);
        m_total = 0;
        for (int p = 0; p < KP; p++) begin
            m_d[p]   = int'($urandom_range(dmax, dmin));
            m_len[p] = FW + LAT + m_d[p] + 1;
            m_total += m_len[p];
        end
    endtask

    task automatic step();
        int  o, p, j, w;
        bit  in_run, is_fin, e_v, s, cd, r;
        int  e_a, e_b, e_k, e_perf;
        @(posedge clk);
        #1;
        cyc++;
        in_run = 0; is_fin = 0; o = 0; p = 0; j = 0;
        if (m_run) begin
            o = cyc - m_t0 - 1;
            if (o >= m_total) begin
                is_fin = 1;
            end else begin
                in_run = 1;
                j = o;
                while (j >= m_len[p]) begin
                    j -= m_len[p];
                    p++;
                end
            end
        end
        if (in_run) begin
            w   = (j < FW) ? j : FW - 1;
            e_a = B0 + p * FW + w;
            e_b = B1 + p * FW + w;
            e_k = p;
        end else if (is_fin) begin
            e_a = B0 + KP * FW - 1;
            e_b = B1 + KP * FW - 1;
            e_k = KP - 1;
        end else begin
            e_a = m_hold_a;
            e_b = m_hold_b;
            e_k = m_hold_k;
        end
        e_v    = in_run && j >= LAT && j <= FW - 1 + LAT;
        e_perf = m_run ? o : m_perf;

        chk("addra", 32'(weight_addra), e_a);
        chk("addrb", 32'(weight_addrb), e_b);
        chk("kernel_idx", 32'(kernel_idx), e_k);
        chk("busy", 32'(busy), 32'(in_run));
        chk("done", 32'(done), 32'(is_fin));
        chk("conv_start", 32'(conv_start), 32'(in_run && j == FW + LAT));
        chk("weight_valid", 32'(weight_valid), 32'(e_v));
        if (e_v) begin
            chk("weight_index", 32'(weight_index), j - LAT);
            chk("douta_tag", hist_a[LAT-1], B0 + p * FW + (j - LAT));
            chk("doutb_tag", hist_b[LAT-1], B1 + p * FW + (j - LAT));
        end
`ifdef L3_SCHED_PERF_EN
        chk("perf_cycles", 32'(perf_cycles), e_perf);
`endif
        if (weight_valid) cnt_v++;
        if (conv_start) cnt_cs++;
        if (done) begin
            cnt_done++;
            last_done_cyc = cyc;
        end
        for (int i = 15; i > 0; i--) begin
            hist_a[i] = hist_a[i-1];
            hist_b[i] = hist_b[i-1];
        end
        hist_a[0] = int'(weight_addra);
        hist_b[0] = int'(weight_addrb);

        r = 1;
        if (in_run) begin
            if (o == pol_rst_o) r = 0;
            cd = pol_cd_hold || (j == FW + LAT + m_d[p]) ||
                 (pol_stray && j <= FW + LAT && $urandom_range(7, 0) == 0);
            s  = pol_start_hold || (pol_start_noise && $urandom_range(1, 0) == 1);
        end else if (is_fin) begin
            cd = pol_cd_hold || (pol_stray && $urandom_range(1, 0) == 1);
            s  = pol_start_hold;
        end else begin
            cd = pol_cd_hold || (pol_stray && $urandom_range(1, 0) == 1);
            s  = req_start || pol_start_hold;
        end
        rst       = r;
        start     = s;
        conv_done = cd;

        if (!r) begin
            m_run = 0; m_hold_a = 0; m_hold_b = 0; m_hold_k = 0; m_perf = 0;
        end else if (is_fin) begin
            m_run    = 0;
            m_hold_a = B0 + KP * FW - 1;
            m_hold_b = B1 + KP * FW - 1;
            m_hold_k = KP - 1;
            m_perf   = m_total;
        end else if (!m_run && s) begin
            m_run = 1; m_t0 = cyc; cnt_v = 0; cnt_cs = 0; cnt_done = 0;
        end
    endtask

    task automatic finish_run(input int exp_done);
        int n = 0;
        while (m_run && n < 4000) begin
            step();
            n++;
        end
        chk("run_bound", 32'(n < 4000), 1);
        chk("done_count", cnt_done, exp_done);
        if (exp_done == 1) begin
            chk("valid_count", cnt_v, KP * FW);
            chk("conv_start_count", cnt_cs, KP);
        end
    endtask

    task automatic do_run();
        req_start = 1;
        step();
        req_start = 0;
        finish_run(1);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            hist_a[i] = 0;
            hist_b[i] = 0;
        end
        repeat (3) @(posedge clk);
        repeat (4) step();

        // Directed full run, D = 10 every pair
        set_delays(10, 10);
        do_run();
        chk("done_time", last_done_cyc - m_t0, 1313);
`ifdef L3_SCHED_PERF_EN
        step();
        chk("perf_total", 32'(perf_cycles), 1312);
`endif
        repeat (3) step();

        // conv_done held high with stray pulses everywhere
        pol_cd_hold = 1;
        set_delays(1, 1);
        do_run();
        chk("held_busy_len", last_done_cyc - m_t0 - 1, 8 * 155);
        pol_cd_hold = 0;
        repeat (2) step();

        // Randomized runs with stray conv_done and start toggling while busy
        pol_stray = 1;
        pol_start_noise = 1;
        for (int k = 0; k < 3; k++) begin
            set_delays(1, 20);
            do_run();
            repeat (int'($urandom_range(4, 1))) step();
        end
        pol_start_noise = 0;

        // start held high: a second run begins straight out of IDLE
        set_delays(1, 6);
        pol_start_hold = 1;
        step();
        finish_run(1);
        step();
        pol_start_hold = 0;
        chk("restart_active", 32'(busy || m_run), 1);
        finish_run(1);
        repeat (2) step();

        // Reset at pair 3, word 70
        set_delays(1, 12);
        pol_rst_o = m_len[0] + m_len[1] + m_len[2] + 70;
        do_run_reset();
        pol_rst_o = -1;
        repeat (5) step();
        chk("no_done_after_reset", cnt_done, 0);
        set_delays(1, 8);
        do_run();
        repeat (2) step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    task automatic do_run_reset();
        req_start = 1;
        step();
        req_start = 0;
        finish_run(0);
    endtask

endmodule

// File: doc/l3_kernel_scheduler.md
# l3_kernel_scheduler

Sequences layer-3 (C3) convolution of the LeNet-5 pipeline across all kernel pairs. For each pair it streams the 151-word filter and bias from the dual-port L3 weight memory and tags each returned word with its index. It then fires the convolution datapath and waits for its completion before moving to the next pair. It sits between the middle-layer wrapper's top FSM, which supplies `start` and consumes `done`, and the weight ROM, the weight register banks and the conv/pool datapath.

## Interface
Parameters:
- `DATA_WIDTH`, 12: weight-memory address width.
- `KERNEL_PAIRS`, 8: number of kernel pairs; two filters per pair, 16 filters total.
- `FILTER_WORDS`, 151: words per filter (150 weights + 1 bias).
- `FILTER_BASE_0`, 0: port-A base address of filter bank 0.
- `FILTER_BASE_1`, 1208: port-B base address of filter bank 1.
- `READ_LATENCY`, 2: weight-memory read latency in cycles (≥1).

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-low reset (`rst==0` resets on the clock edge).
- `start`  in  1  level; sampled only in IDLE.
- `conv_done`  in  1  convolution of current pair complete; sampled only in CONV.
- `weight_addra`  out  DATA_WIDTH  port-A read address, registered.
- `weight_addrb`  out  DATA_WIDTH  port-B read address, registered.
- `weight_valid`  out  1  weight-memory douta/doutb hold word `weight_index` this cycle.
- `weight_index`  out  8  word index 0..150; 150 is the bias.
- `kernel_idx`  out  3  current pair index 0..KERNEL_PAIRS-1.
- `conv_start`  out  1  one-cycle pulse starting convolution.
- `busy`  out  1  high in LOAD, DRAIN and CONV.
- `done`  out  1  one-cycle pulse at end of the run.

## Operation
- States are IDLE, LOAD, DRAIN, CONV and FIN, one-hot encoded in 5 bits.
- **IDLE**
  - `start==1` goes to LOAD with `kernel_idx=0` and word counter `wc=0`.
- **LOAD**
  - Each cycle drives `weight_addra = FILTER_BASE_0 + kernel_idx*FILTER_WORDS + wc` and `weight_addrb = FILTER_BASE_1 + kernel_idx*FILTER_WORDS + wc`.
  - `wc` increments every cycle. After `wc==FILTER_WORDS-1` the FSM goes to DRAIN.
  - Address arithmetic is unsigned at DATA_WIDTH. The maximum, 2415, fits in 12 bits with no wrap.
- **Valid pipeline**
  - An issued-address flag plus `wc` pass through a READ_LATENCY-deep shift register.
  - Its output drives `weight_valid` and `weight_index`.
- **DRAIN**
  - Lasts exactly READ_LATENCY cycles so that word 150 returns.
  - Then goes to CONV.
- **CONV**
  - `conv_start=1` in the first CONV cycle only.
  - `conv_done` is ignored in that first cycle and accepted from the second CONV cycle on.
  - On an accepted `conv_done`:
    - if `kernel_idx==KERNEL_PAIRS-1`, go to FIN;
    - otherwise increment `kernel_idx`, clear `wc` and go to LOAD.
- **FIN**
  - `done=1` for one cycle, then IDLE. `kernel_idx` holds 7 until the next start.
- **Address outputs**
  - Outside LOAD they hold the last issued value.
- **Ignored inputs**
  - `start` outside IDLE is ignored.
  - `conv_done` outside CONV is ignored.
  - If `start` is held high, a new run begins on the cycle after FIN.
- **Reset values** (`rst==0`)
  - `st=IDLE`, `wc=0`.
  - `kernel_idx=0`, `weight_addra=0`, `weight_addrb=0`.
  - `weight_valid=0`, `weight_index=0`, `conv_start=0`, `busy=0`, `done=0`.
  - The valid pipeline is cleared.
  - A reset mid-run aborts immediately, and no `done` is produced.

## Timing
- Start sampled in cycle t → first LOAD cycle t+1. Word k address is valid at t+1+k.
- `weight_valid` with `weight_index=k` occurs at t+1+k+READ_LATENCY.
- Per pair: 151 LOAD cycles + READ_LATENCY DRAIN cycles + CONV length.
- With `conv_done` arriving D≥1 cycles after the `conv_start` cycle, CONV lasts D+1 cycles.
- Per-pair period = 151 + READ_LATENCY + D + 1.
- `done` follows the last CONV cycle by one cycle.
- `busy` falls in the FIN cycle.

## Configuration
- `L3_SCHED_PERF_EN` defined:
  - Adds output `perf_cycles` [15:0], which counts cycles with `busy==1`.
  - It clears on the IDLE→LOAD transition and freezes at FIN; it holds its value and saturates at 16'hFFFF.
  - Reset value is 0.
- Undefined: the port and counter are absent, and all other behaviour is identical.

## Test plan
- **Full run.** Reset, then `start` pulse at t=0, READ_LATENCY=2, `conv_done` pulsed 10 cycles after each `conv_start`.
  - Pair 0 addresses are 0..150 and 1208..1358.
  - Pair 7 addresses are 1057..1207 and 2265..2415.
  - 8 `conv_start` pulses; `done` at cycle 1313.
  - `perf_cycles=1312` with the macro defined.
- **Valid tagging.**
  - Drive a model ROM with dout = address.
  - Every `weight_valid` cycle shows douta = base_a + `weight_index`.
  - Exactly 151 valids per pair; the index-150 valid arrives 2 cycles after the last address.
- **`conv_done` held high.**
  - Each CONV lasts 2 cycles; the run completes in 8×155 = 1240 busy cycles.
  - Stray `conv_done` during LOAD is ignored.
- **`start` while busy.**
  - Toggle `start` during LOAD and CONV: no restart and `kernel_idx` undisturbed.
  - `start` held high: a second run begins the cycle after `done`.
- **Reset mid-run.**
  - Drive `rst=0` at pair 3, word 70.
  - Next cycle all outputs are at reset values; no `done` is produced.
  - A fresh `start` restarts at pair 0, address 0/1208.
